// File: rtl/antirebote_pkg.sv
// Shared channel state encoding and default parameters for the multichannel debouncer.
// No logic here; latency and backpressure are properties of the modules that import it.
package antirebote_pkg;

    typedef enum logic {
        ESTABLE   = 1'b0,
        VALIDANDO = 1'b1
    } estado_t;

    localparam int   N_CANALES_DEF    = 4;
    localparam int   CUENTA_DB_DEF    = 5;
    localparam int   CUENTA_LARGA_DEF = 20;
    localparam logic NIVEL_REPOSO_DEF = 1'b1;

endpackage

// File: rtl/antirebote_canal.sv
// One button channel: 2-flop synchroniser, debounce FSM, hold counter and registered event pulses.
// Pin-to-output latency 2 + 2**CUENTA_DB cycles; no backpressure, outputs are always valid.
module antirebote_canal
    import antirebote_pkg::*;
#(
    parameter int   CUENTA_DB    = CUENTA_DB_DEF,
    parameter int   CUENTA_LARGA = CUENTA_LARGA_DEF,
    parameter logic NIVEL_REPOSO = NIVEL_REPOSO_DEF
) (
    input  logic clk,
    input  logic rst_n_pi,
    input  logic boton_pi,
    output logic boton_debounce_o,
    output logic presion_o,
    output logic liberacion_o,
    output logic larga_o
);

    localparam logic [CUENTA_DB-1:0]    CNT_MAX  = '1;
    localparam logic [CUENTA_LARGA-1:0] HOLD_MAX = '1;
    localparam logic [CUENTA_LARGA-1:0] HOLD_PRE = HOLD_MAX - 1'b1;

    logic                    sync_q1, sync_q2;
    estado_t                 estado_q, estado_d;
    logic [CUENTA_DB-1:0]    cnt_q, cnt_d;
    logic                    nivel_q, nivel_d;
    logic [CUENTA_LARGA-1:0] hold_q, hold_d;
    logic                    presion_d, liberacion_d, larga_d;
    logic                    transicion;
    logic                    activo_q;

    assign activo_q   = (nivel_q != NIVEL_REPOSO);
    assign transicion = (nivel_d != nivel_q);

    always_ff @(posedge clk or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            sync_q1 <= NIVEL_REPOSO;
            sync_q2 <= NIVEL_REPOSO;
        end else begin
            sync_q1 <= boton_pi;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        nivel_d  = nivel_q;
        case (estado_q)
            ESTABLE: begin
                cnt_d = '0;
                if (sync_q2 != nivel_q) begin
                    estado_d = VALIDANDO;
                    cnt_d[0] = 1'b1;
                end
            end
            VALIDANDO: begin
                if (sync_q2 == nivel_q) begin
                    estado_d = ESTABLE;
                    cnt_d    = '0;
                end else if (cnt_q == CNT_MAX) begin
                    // Last of the consecutive mismatching samples: commit the new level.
                    estado_d = ESTABLE;
                    cnt_d    = '0;
                    nivel_d  = sync_q2;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = ESTABLE;
                cnt_d    = '0;
            end
        endcase
    end

    always_comb begin
        hold_d       = hold_q;
        presion_d    = 1'b0;
        liberacion_d = 1'b0;
        larga_d      = 1'b0;
        if (transicion) begin
            hold_d       = '0;
            presion_d    = (nivel_d != NIVEL_REPOSO);
            liberacion_d = (nivel_d == NIVEL_REPOSO);
        end else if (activo_q) begin
            // Pulse is raised together with the counter landing on its saturation value.
            larga_d = (hold_q == HOLD_PRE);
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            estado_q     <= ESTABLE;
            cnt_q        <= '0;
            nivel_q      <= NIVEL_REPOSO;
            hold_q       <= '0;
            presion_o    <= 1'b0;
            liberacion_o <= 1'b0;
            larga_o      <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            cnt_q        <= cnt_d;
            nivel_q      <= nivel_d;
            hold_q       <= hold_d;
            presion_o    <= presion_d;
            liberacion_o <= liberacion_d;
            larga_o      <= larga_d;
        end
    end

    assign boton_debounce_o = nivel_q;

endmodule

// File: rtl/antirebote_multicanal.sv
// N_CANALES independent debounced buttons with press, release and long-press pulses.
// Pin-to-output latency 2 + 2**CUENTA_DB cycles; no backpressure, outputs are always valid.
module antirebote_multicanal
    import antirebote_pkg::*;
#(
    parameter int   N_CANALES    = N_CANALES_DEF,
    parameter int   CUENTA_DB    = CUENTA_DB_DEF,
    parameter int   CUENTA_LARGA = CUENTA_LARGA_DEF,
    parameter logic NIVEL_REPOSO = NIVEL_REPOSO_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n_pi,
    input  logic [N_CANALES-1:0] boton_pi,
    output logic [N_CANALES-1:0] boton_debounce_o,
    output logic [N_CANALES-1:0] presion_o,
    output logic [N_CANALES-1:0] liberacion_o,
    output logic [N_CANALES-1:0] larga_o
);

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        antirebote_canal #(
            .CUENTA_DB    (CUENTA_DB),
            .CUENTA_LARGA (CUENTA_LARGA),
            .NIVEL_REPOSO (NIVEL_REPOSO)
        ) u_canal (
            .clk              (clk),
            .rst_n_pi         (rst_n_pi),
            .boton_pi         (boton_pi[i]),
            .boton_debounce_o (boton_debounce_o[i]),
            .presion_o        (presion_o[i]),
            .liberacion_o     (liberacion_o[i]),
            .larga_o          (larga_o[i])
        );
    end

endmodule

// File: doc/antirebote_multicanal.md
ANTIREBOTE_MULTICANAL -- requirements
Module: antirebote_multicanal

Interface
REQ-001 SHALL have parameter N_CANALES, default 4, number of independent button channels (1..32).
REQ-002 SHALL have parameter CUENTA_DB, default 5, debounce counter width; stability window UMBRAL = 2**CUENTA_DB cycles.
REQ-003 SHALL have parameter CUENTA_LARGA, default 20, hold counter width; long-press window LARGO = 2**CUENTA_LARGA cycles.
REQ-004 SHALL have parameter NIVEL_REPOSO, default 1'b1, idle (released) level of every raw input; active level is its complement.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 rst_n_pi  input  1  reset, asynchronous, active-low.
REQ-007 boton_pi  input  N_CANALES  raw asynchronous button levels.
REQ-008 boton_debounce_o  output  N_CANALES  debounced level per channel.
REQ-009 presion_o  output  N_CANALES  one-cycle pulse on debounced idle->active transition.
REQ-010 liberacion_o  output  N_CANALES  one-cycle pulse on debounced active->idle transition.
REQ-011 larga_o  output  N_CANALES  one-cycle pulse when a press has been held LARGO cycles.

Function
REQ-012 Each raw input SHALL pass a 2-flop synchroniser (reset to NIVEL_REPOSO) before any comparison.
REQ-013 Each channel SHALL be an FSM with states ESTABLE and VALIDANDO and a CUENTA_DB-bit counter.
REQ-014 ESTABLE: synced input == debounced level -> stay, counter 0; mismatch -> VALIDANDO, counter 1.
REQ-015 VALIDANDO: synced input returns equal to debounced level -> ESTABLE, counter 0, no output change.
REQ-016 VALIDANDO: mismatch and counter == UMBRAL-1 -> debounced level takes synced value, counter 0, ESTABLE; else counter +1.
REQ-017 Debounced level SHALL therefore change only after UMBRAL consecutive mismatching synced samples; raw-pin-to-output latency = 2 + UMBRAL cycles.
REQ-018 presion_o/liberacion_o SHALL be registered and high exactly in the first cycle the new debounced level is visible, never both at once.
REQ-019 Hold counter SHALL clear on every debounced transition and increment each cycle while debounced level is active, saturating at LARGO-1.
REQ-020 larga_o SHALL pulse once, the cycle the hold counter reaches LARGO-1; no repeat until release and new press.
REQ-021 Release before LARGO SHALL produce no larga_o pulse.
REQ-022 Counters SHALL never wrap; debounce counter maximum is UMBRAL-1.
REQ-023 Channels SHALL be fully independent; simultaneous events on several channels SHALL be handled in the same cycle.
REQ-024 A glitch shorter than UMBRAL cycles on any channel SHALL produce no output change and no pulse.

Reset
REQ-025 On rst_n_pi low: synchronisers and boton_debounce_o = NIVEL_REPOSO per bit, FSM = ESTABLE, all counters 0, presion_o/liberacion_o/larga_o = 0.
REQ-026 Reset asserted mid-validation or mid-hold SHALL discard progress; no pulse SHALL be emitted on reset assertion or release.
REQ-027 After reset release a pin already at the active level SHALL produce presion_o after 2 + UMBRAL cycles.

Structure
REQ-028 Package antirebote_pkg SHALL hold the channel state enum (ESTABLE, VALIDANDO) and default parameter constants.
REQ-029 Per-channel logic SHALL be sub-module antirebote_canal (synchroniser, FSM, counters, pulse flops), instantiated N_CANALES times via generate.
REQ-030 Top level SHALL contain only parameter passing and bit slicing; no shared state between channels.

Verification (N_CANALES=4, CUENTA_DB=2 -> UMBRAL=4, CUENTA_LARGA=3 -> LARGO=8, NIVEL_REPOSO=1)
REQ-031 Reset, inputs 4'b1111 -> outputs 4'b1111, all pulses 0, held for 20 cycles.
REQ-032 boton_pi[0] low permanently at cycle 0 -> boton_debounce_o[0]=0 and presion_o[0]=1 for one cycle at cycle 6.
REQ-033 boton_pi[1] low for 3 cycles then high -> no change on any output of channel 1.
REQ-034 boton_pi[2] held low 20 cycles -> presion_o[2] once, larga_o[2] exactly once 7 cycles after the presion_o pulse; on release liberacion_o[2] 6 cycles after the pin goes high.
REQ-035 boton_pi[3:0] all driven low in same cycle -> presion_o = 4'b1111 in one cycle.
REQ-036 rst_n_pi pulsed low during VALIDANDO of channel 0 (counter=2) -> outputs return to 4'b1111, no pulse; pin still low -> presion_o[0] 6 cycles after reset release.
